// File: rtl/hyperspace_pkg.sv
// Shared definitions for the HyperSpace GPIO streaming link: pad bit map,
// pad direction mask and the beat formats carried by the bridge FIFOs.
package hyperspace_pkg;

    localparam int PAD_W           = 38;
    localparam int PAD_IN_DATA_MSB = 37;
    localparam int PAD_IN_DATA_LSB = 30;
    localparam int PAD_IN_LAST     = 29;
    localparam int PAD_IN_VALID    = 28;
    localparam int PAD_IN_READY    = 27;
    localparam int PAD_OUT_READY   = 18;
    localparam int PAD_OUT_VALID   = 17;
    localparam int PAD_OUT_LAST    = 16;

    // Pads we drive (in_ready, out_valid, out_last, out_data) are 0; every other pad is an input.
    localparam logic [PAD_W-1:0] OEB_MASK = 38'h3F_F7FC_0000;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } in_beat_t;

    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } out_beat_t;

    // The host presents its byte MSB-first on the pads, i.e. bit i lands on pad 37-i.
    function automatic logic [7:0] bit_reverse8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered ready; ready only
// rises once the FIFO has seen one full cycle out of reset.
module stream_fifo
    import hyperspace_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         RSTB,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_pop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ready;
    logic          r_alive;

    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_count_next;

    assign w_push       = i_push && r_ready;
    assign w_pop        = i_pop && (r_count != '0);
    assign w_count_next = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (RSTB) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
            r_alive  <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            r_ready <= r_alive && (w_count_next < FULL_COUNT);
            r_count <= w_count_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_ready = r_ready;
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/gpio_stream_bridge.sv
// Chip-side pad endpoint of the HyperSpace GPIO link: pad input stream to m_axis,
// s_axis result stream to pads, with per-direction status counters.
module gpio_stream_bridge
    import hyperspace_pkg::*;
#(
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             RSTB,
    input  logic [37:0]      io_in,
    output logic [37:0]      io_out,
    output logic [37:0]      io_oeb,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    input  logic [15:0]      s_axis_tdata,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [CNT_W-1:0] in_beats,
    output logic [CNT_W-1:0] out_frames
);

    in_beat_t   w_in_wr;
    in_beat_t   w_in_rd;
    logic       w_in_ready;
    logic       w_in_xfer;

    out_beat_t  w_s_beat;
    out_beat_t  w_ofifo_head;
    logic       w_ofifo_ready;
    logic       w_ofifo_valid;
    logic       w_s_accept;
    logic       w_out_adv;
    logic       w_bypass;
    logic       w_out_xfer;
    logic [37:0] w_io_out;

    out_beat_t        r_out_beat;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_in_beats;
    logic [CNT_W-1:0] r_out_frames;

    // Pads that carry nothing for this endpoint.
    logic w_unused_pad_bits;
    assign w_unused_pad_bits = ^{io_in[PAD_IN_READY:PAD_OUT_READY+1], io_in[PAD_OUT_VALID:0]};

    // Pad input -> core
    assign w_in_wr.data = bit_reverse8(io_in[PAD_IN_DATA_MSB:PAD_IN_DATA_LSB]);
    assign w_in_wr.last = io_in[PAD_IN_LAST];
    assign w_in_xfer    = io_in[PAD_IN_VALID] && w_in_ready;

    stream_fifo #(.W($bits(in_beat_t)), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clock   (clock),
        .RSTB    (RSTB),
        .i_push  (io_in[PAD_IN_VALID]),
        .i_data  (w_in_wr),
        .o_ready (w_in_ready),
        .o_valid (m_axis_tvalid),
        .o_data  (w_in_rd),
        .i_pop   (m_axis_tready)
    );

    assign m_axis_tdata = w_in_rd.data;
    assign m_axis_tlast = w_in_rd.last;

    // Core -> pad output; a beat skips the FIFO when the FIFO is empty and the pad register can take it.
    assign w_s_beat.data = s_axis_tdata;
    assign w_s_beat.last = s_axis_tlast;
    assign w_s_accept    = s_axis_tvalid && w_ofifo_ready;
    assign w_out_adv     = !r_out_valid || io_in[PAD_OUT_READY];
    assign w_bypass      = w_s_accept && !w_ofifo_valid && w_out_adv;
    assign w_out_xfer    = r_out_valid && io_in[PAD_OUT_READY];

    stream_fifo #(.W($bits(out_beat_t)), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clock   (clock),
        .RSTB    (RSTB),
        .i_push  (s_axis_tvalid && !w_bypass),
        .i_data  (w_s_beat),
        .o_ready (w_ofifo_ready),
        .o_valid (w_ofifo_valid),
        .o_data  (w_ofifo_head),
        .i_pop   (w_out_adv)
    );

    assign s_axis_tready = w_ofifo_ready;

    always_ff @(posedge clock) begin
        if (RSTB) begin
            r_out_valid <= 1'b0;
            r_out_beat  <= '0;
        end else if (w_out_adv) begin
            if (w_ofifo_valid) begin
                r_out_valid <= 1'b1;
                r_out_beat  <= w_ofifo_head;
            end else if (w_s_accept) begin
                r_out_valid <= 1'b1;
                r_out_beat  <= w_s_beat;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (RSTB) begin
            r_in_beats   <= '0;
            r_out_frames <= '0;
        end else begin
            if (w_in_xfer)                     r_in_beats   <= r_in_beats + 1'b1;
            if (w_out_xfer && r_out_beat.last) r_out_frames <= r_out_frames + 1'b1;
        end
    end

    assign in_beats   = r_in_beats;
    assign out_frames = r_out_frames;

    // NOTE: the whole vector gets a default first so no bit can infer a latch.
    always_comb begin
        w_io_out                = '0;
        w_io_out[PAD_IN_READY]  = w_in_ready;
        w_io_out[PAD_OUT_VALID] = r_out_valid;
        w_io_out[PAD_OUT_LAST]  = r_out_beat.last;
        w_io_out[15:0]          = r_out_beat.data;
    end

    assign io_out = w_io_out;
    assign io_oeb = OEB_MASK;

endmodule

// File: tb/tb_gpio_stream_bridge.sv
// Randomised bench for gpio_stream_bridge: a queue-based transaction model
// predicts every pad/AXI beat, the handshake readies and the status counters.
module tb_gpio_stream_bridge;

    localparam int IN_DEPTH  = 4;
    localparam int OUT_DEPTH = 4;
    localparam int CNT_W     = 16;
    localparam logic [37:0] OEB_EXP = 38'h3F_F7FC_0000;

    logic             clock = 1'b0;
    logic             RSTB  = 1'b1;
    logic [37:0]      io_in = '0;
    logic [37:0]      io_out;
    logic [37:0]      io_oeb;
    logic [7:0]       m_axis_tdata;
    logic             m_axis_tlast;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b0;
    logic [15:0]      s_axis_tdata  = '0;
    logic             s_axis_tlast  = 1'b0;
    logic             s_axis_tvalid = 1'b0;
    logic             s_axis_tready;
    logic [CNT_W-1:0] in_beats;
    logic [CNT_W-1:0] out_frames;

    always #5 clock = ~clock;

    gpio_stream_bridge #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .CNT_W(CNT_W)) dut (
        .clock         (clock),
        .RSTB          (RSTB),
        .io_in         (io_in),
        .io_out        (io_out),
        .io_oeb        (io_oeb),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .in_beats      (in_beats),
        .out_frames    (out_frames)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction model: {last, data} beats.
    logic [8:0]  host_q[$];   // host still has to send on the pads
    logic [16:0] core_q[$];   // core still has to send on s_axis
    logic [8:0]  in_q[$];     // accepted from pads, not yet taken by the core
    logic [16:0] out_q[$];    // accepted from core, not yet sent on the pads
    logic [CNT_W-1:0] exp_in_beats;
    logic [CNT_W-1:0] exp_out_frames;

    int in_pct  = 100;
    int m_pct   = 100;
    int s_pct   = 100;
    int out_pct = 100;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    // One clock: check the DUT against the model, drive inputs, then advance the model
    // by the transfers the coming edge performs.
    task automatic step();
        logic [63:0] junk;
        logic h_valid, c_valid, o_ready, t_ready;
        logic in_x, pop_x, out_x, push_x;
        @(negedge clock);
        check("in_ready", 64'(io_out[27]), 64'(in_q.size() < IN_DEPTH));
        check("m_tvalid", 64'(m_axis_tvalid), 64'(in_q.size() != 0));
        if (in_q.size() != 0) check("m_beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(in_q[0]));
        check("s_tready", 64'(s_axis_tready), 64'(out_q.size() <= OUT_DEPTH));
        check("out_valid", 64'(io_out[17]), 64'(out_q.size() != 0));
        if (out_q.size() != 0) check("out_beat", 64'(io_out[16:0]), 64'(out_q[0]));
        check("io_out_idle", 64'(io_out & OEB_EXP), 64'd0);
        check("in_beats", 64'(in_beats), 64'(exp_in_beats));
        check("out_frames", 64'(out_frames), 64'(exp_out_frames));

        junk    = {$urandom(), $urandom()};
        h_valid = (host_q.size() != 0) && roll(in_pct);
        o_ready = roll(out_pct);
        t_ready = roll(m_pct);
        c_valid = (core_q.size() != 0) && roll(s_pct);
        io_in     = junk[37:0];
        io_in[28] = h_valid;
        io_in[18] = o_ready;
        if (h_valid) begin
            io_in[37:30] = rev8(host_q[0][7:0]);
            io_in[29]    = host_q[0][8];
        end
        m_axis_tready = t_ready;
        s_axis_tvalid = c_valid;
        {s_axis_tlast, s_axis_tdata} = c_valid ? core_q[0] : junk[63:47];

        in_x   = h_valid && (in_q.size() < IN_DEPTH);
        pop_x  = t_ready && (in_q.size() != 0);
        out_x  = o_ready && (out_q.size() != 0);
        push_x = c_valid && (out_q.size() <= OUT_DEPTH);
        if (pop_x) void'(in_q.pop_front());
        if (in_x) begin
            in_q.push_back(host_q.pop_front());
            exp_in_beats++;
        end
        if (out_x) begin
            if (out_q[0][16]) exp_out_frames++;
            void'(out_q.pop_front());
        end
        if (push_x) out_q.push_back(core_q.pop_front());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        RSTB = 1'b1;
        io_in = '0;
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0;
        host_q.delete(); core_q.delete(); in_q.delete(); out_q.delete();
        exp_in_beats = '0;
        exp_out_frames = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check("rst_io_out", 64'(io_out), 64'd0);
            check("rst_io_oeb", 64'(io_oeb), 64'(OEB_EXP));
            check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
            check("rst_s_tready", 64'(s_axis_tready), 64'd0);
            check("rst_counters", 64'({in_beats, out_frames}), 64'd0);
        end
        RSTB = 1'b0;
        @(negedge clock);
        check("rel_in_ready_low", 64'(io_out[27]), 64'd0);
        check("rel_s_tready_low", 64'(s_axis_tready), 64'd0);
    endtask

    task automatic set_rates(input int ip, input int mp, input int sp, input int op);
        in_pct = ip; m_pct = mp; s_pct = sp; out_pct = op;
    endtask

    initial begin
        int guard;
        exp_in_beats = '0;
        exp_out_frames = '0;
        do_reset(5);

        // Bit reversal: pad bytes 80, 01, A5 must reach the core as 01, 80, A5.
        set_rates(100, 100, 0, 100);
        host_q.push_back(9'h001);
        host_q.push_back(9'h080);
        host_q.push_back(9'h1A5);
        run(6);
        check("bitrev_in_beats", 64'(in_beats), 64'd3);

        // Input backpressure: core stalled, exactly IN_DEPTH beats get in.
        set_rates(100, 0, 0, 100);
        for (int i = 0; i < 10; i++) host_q.push_back(9'($urandom()));
        run(10);
        check("bp_in_beats", 64'(in_beats), 64'd7);
        check("bp_in_ready", 64'(io_out[27]), 64'd0);
        m_pct = 100;
        run(20);
        check("bp_resume_in_beats", 64'(in_beats), 64'd13);
        check("bp_drained", 64'(m_axis_tvalid), 64'd0);

        // Output stall: 1234 held on the pads until out_ready rises.
        set_rates(0, 100, 100, 0);
        core_q.push_back(17'h01234);
        core_q.push_back(17'h1BEEF);
        run(22);
        check("stall_out_data", 64'(io_out[15:0]), 64'h1234);
        check("stall_out_valid", 64'(io_out[17]), 64'd1);
        out_pct = 100;
        run(5);
        check("stall_out_frames", 64'(out_frames), 64'd1);

        // Output FIFO fills: s_axis_tready drops with register + FIFO holding 5 beats.
        set_rates(0, 100, 100, 0);
        for (int i = 0; i < 8; i++) core_q.push_back(17'($urandom()));
        run(10);
        check("ofull_s_tready", 64'(s_axis_tready), 64'd0);
        check("ofull_out_valid", 64'(io_out[17]), 64'd1);
        out_pct = 100;
        run(15);
        check("ofull_drained", 64'(io_out[17]), 64'd0);

        // Full-rate streaming from a fresh reset.
        do_reset(3);
        set_rates(100, 100, 100, 100);
        for (int i = 0; i < 2048; i++) host_q.push_back({(i == 2047), 8'($urandom())});
        for (int i = 0; i < 1536; i++) core_q.push_back({(i == 1535), 16'($urandom())});
        run(2048);
        check("fr_every_cycle", 64'(in_beats), 64'd2047);
        run(4);
        check("fr_in_beats", 64'(in_beats), 64'd2048);
        check("fr_out_frames", 64'(out_frames), 64'd1);

        // Random traffic with random backpressure on all four interfaces.
        for (int r = 0; r < 4; r++) begin
            set_rates(int'($urandom_range(100, 20)), int'($urandom_range(100, 20)),
                      int'($urandom_range(100, 20)), int'($urandom_range(100, 20)));
            for (int i = 0; i < 300; i++) begin
                host_q.push_back(9'($urandom()));
                core_q.push_back(17'($urandom()));
            end
            guard = 0;
            while ((host_q.size() + core_q.size() + in_q.size() + out_q.size()) != 0 && guard < 3000) begin
                step();
                guard++;
            end
            check("rand_drained_in_time", 64'(guard < 3000), 64'd1);
        end

        // Reset mid-frame with 3 beats in each FIFO.
        set_rates(100, 0, 100, 0);
        for (int i = 0; i < 3; i++) host_q.push_back(9'($urandom()));
        for (int i = 0; i < 4; i++) core_q.push_back(17'($urandom()));
        run(8);
        check("mr_m_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("mr_out_valid", 64'(io_out[17]), 64'd1);
        do_reset(2);
        set_rates(100, 100, 100, 100);
        host_q.push_back(9'h13C);
        core_q.push_back(17'h1CAFE);
        run(6);
        check("mr_in_beats", 64'(in_beats), 64'd1);
        check("mr_out_frames", 64'(out_frames), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
